// File: rtl/dmem_pkg.sv
// Shared encodings for the banked data memory: access-size codes and FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SPLIT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Number of bytes touched by a write_mem / read_mem[1:0] size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        logic [2:0] n;
        case (code)
            SZ_WORD: n = 3'd4;
            SZ_HALF: n = 3'd2;
            SZ_BYTE: n = 3'd1;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// One byte lane of the data memory: byte-wide storage, synchronous write, registered read.
module dmem_lane #(
    parameter int ENTRIES = 256,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [ENTRIES];
    logic [7:0] rdata_r;

    // Storage array write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read data register, only updated by an enabled read so it survives the other half of a split access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 8'h00;
        end else if (en && !we) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_banked.sv
// Four-lane little-endian data memory with a valid/ready request/response handshake
// and unaligned accesses that are split across two consecutive words.
module data_mem_banked
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        write_mem,
    input  logic [2:0]        read_mem,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       out_mem,
    output logic              fault
);

    localparam int ENTRIES = DEPTH_BYTES / 4;
    localparam int LANE_AW = $clog2(ENTRIES);

    state_t state_r, state_s;

    logic [1:0]         off_r;
    logic [LANE_AW-1:0] entry_r;
    logic [2:0]         size_r;
    logic               store_r, sign_r, acc_fault_r, cross_r;
    logic [31:0]        wdata_r;

    logic               resp_valid_r, resp_fault_r;
    logic [31:0]        out_mem_r;

    logic [2:0]         wr_sz_s, rd_sz_s, acc_sz_s;
    logic [ADDR_W:0]    last_s;
    logic               noop_s, fault_s, cross_s;

    logic [1:0]         k_s         [4];
    logic               first_s     [4];
    logic [3:0]         lane_en_s;
    logic [LANE_AW-1:0] lane_addr_s [4];
    logic [7:0]         lane_wdata_s[4];
    logic [7:0]         lane_rdata_s[4];
    logic [7:0]         byte_s      [4];
    logic [31:0]        load_s, resp_data_s;

    // Classify the incoming request: size, range/conflict fault, word-boundary crossing.
    always_comb begin
        wr_sz_s  = size_bytes(write_mem);
        rd_sz_s  = size_bytes(read_mem[1:0]);
        acc_sz_s = (write_mem != SZ_NONE) ? wr_sz_s : rd_sz_s;
        last_s   = {1'b0, address} + (ADDR_W+1)'(acc_sz_s) - (ADDR_W+1)'(1);
        noop_s   = (write_mem == SZ_NONE) && (read_mem[1:0] == SZ_NONE);
        fault_s  = !noop_s && (((write_mem != SZ_NONE) && (read_mem[1:0] != SZ_NONE)) ||
                               (last_s >= (ADDR_W+1)'(DEPTH_BYTES)));
        cross_s  = !noop_s && !fault_s && (({1'b0, address[1:0]} + acc_sz_s) > 3'd4);
    end

    // Capture the request on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_r       <= 2'd0;
            entry_r     <= '0;
            size_r      <= 3'd0;
            store_r     <= 1'b0;
            sign_r      <= 1'b0;
            acc_fault_r <= 1'b0;
            cross_r     <= 1'b0;
            wdata_r     <= 32'h0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            off_r       <= address[1:0];
            entry_r     <= address[LANE_AW+1:2];
            size_r      <= acc_sz_s;
            store_r     <= (write_mem != SZ_NONE);
            sign_r      <= read_mem[2];
            acc_fault_r <= fault_s;
            cross_r     <= cross_s;
            wdata_r     <= write_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; RESP only releases once the response has actually been presented.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = req_valid ? ST_ACC : ST_IDLE;
            ST_ACC:   state_s = cross_r ? ST_SPLIT : ST_RESP;
            ST_SPLIT: state_s = ST_RESP;
            ST_RESP:  state_s = (resp_valid_r && resp_ready) ? ST_IDLE : ST_RESP;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Lane i carries access byte k = i - offset; bytes with offset+k >= 4 belong to the next entry.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            k_s[i]          = 2'(i) - off_r;
            first_s[i]      = ({1'b0, off_r} + {1'b0, k_s[i]}) < 3'd4;
            lane_en_s[i]    = !acc_fault_r && ({1'b0, k_s[i]} < size_r) &&
                              (((state_r == ST_ACC) && first_s[i]) ||
                               ((state_r == ST_SPLIT) && !first_s[i]));
            lane_addr_s[i]  = (state_r == ST_SPLIT) ? (entry_r + LANE_AW'(1)) : entry_r;
            lane_wdata_s[i] = wdata_r[{k_s[i], 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        dmem_lane #(
            .ENTRIES (ENTRIES),
            .AW      (LANE_AW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (lane_en_s[g]),
            .we    (store_r),
            .addr  (lane_addr_s[g]),
            .wdata (lane_wdata_s[g]),
            .rdata (lane_rdata_s[g])
        );
    end

    // Reassemble load bytes in access order and apply the requested extension.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_s[k] = lane_rdata_s[2'(off_r + 2'(k))];
        end
        case (size_r)
            3'd4:    load_s = {byte_s[3], byte_s[2], byte_s[1], byte_s[0]};
            3'd2:    load_s = {{16{sign_r & byte_s[1][7]}}, byte_s[1], byte_s[0]};
            3'd1:    load_s = {{24{sign_r & byte_s[0][7]}}, byte_s[0]};
            default: load_s = 32'h0;
        endcase
        resp_data_s = (!store_r && !acc_fault_r) ? load_s : 32'h0;
    end

    // Response registers: loaded on the first RESP cycle, held until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            out_mem_r    <= 32'h0;
        end else if ((state_r == ST_RESP) && !resp_valid_r) begin
            resp_valid_r <= 1'b1;
            resp_fault_r <= acc_fault_r;
            out_mem_r    <= resp_data_s;
        end else if ((state_r == ST_RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            out_mem_r    <= 32'h0;
        end
    end

    assign req_ready  = (state_r == ST_IDLE);
    assign resp_valid = resp_valid_r;
    assign out_mem    = out_mem_r;
    assign fault      = resp_fault_r;

endmodule

// File: tb/tb_data_mem_banked.sv
// Self-checking bench for data_mem_banked: directed vector table, handshake/reset
// sequences, and randomized traffic against a byte-array reference model.
module tb_data_mem_banked;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  write_mem = 2'b00;
    logic [2:0]  read_mem = 3'b000;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] out_mem;
    logic        fault;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_m [DEPTH];

    typedef struct {
        logic [1:0]  wm;
        logic [2:0]  rm;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] eo;
        logic        ef;
        int          el;
    } vec_t;

    vec_t tbl[$];

    data_mem_banked #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .write_mem  (write_mem),
        .read_mem   (read_mem),
        .address    (address),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out_mem    (out_mem),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int sz(input logic [1:0] c);
        case (c)
            2'b01:   return 4;
            2'b10:   return 2;
            2'b11:   return 1;
            default: return 0;
        endcase
    endfunction

    // Reference model: computes expected response and applies stores to mem_m.
    task automatic model(input logic [1:0] wm, input logic [2:0] rm, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] eo, output logic ef,
                         output int el);
        int ws, rs, n, off;
        longint unsigned last;
        ws = sz(wm);
        rs = sz(rm[1:0]);
        eo = 32'h0;
        ef = 1'b0;
        el = 2;
        if (ws == 0 && rs == 0) return;
        if (ws != 0 && rs != 0) begin
            ef = 1'b1;
            return;
        end
        n = (ws != 0) ? ws : rs;
        last = longint'(addr) + longint'(n) - 1;
        if (last >= longint'(DEPTH)) begin
            ef = 1'b1;
            return;
        end
        off = int'(addr % 4);
        if ((n == 4 && off != 0) || (n == 2 && off == 3)) el = 3;
        if (ws != 0) begin
            for (int k = 0; k < n; k++) mem_m[int'(addr) + k] = wd[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++) eo = eo | (32'(mem_m[int'(addr) + k]) << (8*k));
            if (n < 4 && rm[2] && eo[8*n-1]) eo = eo | ~((32'd1 << (8*n)) - 32'd1);
        end
    endtask

    // Issue one request, check latency/result, hold the response for `hold` cycles, then consume it.
    task automatic run(input string tag, input logic [1:0] wm, input logic [2:0] rm,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] eo,
                       input logic ef, input int el, input int hold);
        int lat;
        @(negedge clk);
        write_mem = wm; read_mem = rm; address = addr; write_data = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        chk({tag, "_out"}, out_mem, eo);
        chk({tag, "_fault"}, 32'(fault), 32'(ef));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_out"}, out_mem, eo);
            chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_consumed"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic run_model(input string tag, input logic [1:0] wm, input logic [2:0] rm,
                             input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] eo;
        logic        ef;
        int          el;
        model(wm, rm, addr, wd, eo, ef, el);
        run(tag, wm, rm, addr, wd, eo, ef, el, hold);
    endtask

    initial begin
        logic [31:0] eo, bp_exp;
        logic        ef;
        int          el, lat;

        // Reset state, asynchronous: visible before any clock edge
        #2;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_out", out_mem, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Known contents everywhere
        for (int a = 0; a < DEPTH; a += 4) run_model("fill", 2'b01, 3'b000, 32'(a), $urandom, 0);

        // Directed vectors
        tbl.push_back('{2'b01, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b001, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2});
        tbl.push_back('{2'b11, 3'b000, 32'h21, 32'h00000080, 32'h0, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b111, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b011, 32'h21, 32'h0, 32'h00000080, 1'b0, 2});
        tbl.push_back('{2'b01, 3'b000, 32'h0E, 32'h11223344, 32'h0, 1'b0, 3});
        tbl.push_back('{2'b00, 3'b001, 32'h0E, 32'h0, 32'h11223344, 1'b0, 3});
        tbl.push_back('{2'b00, 3'b010, 32'h0F, 32'h0, 32'h00002233, 1'b0, 3});
        tbl.push_back('{2'b00, 3'b101, 32'h10, 32'h0, 32'hDEAD1122, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b110, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2});
        tbl.push_back('{2'b11, 3'b000, DEPTH-2, 32'h5A, 32'h0, 1'b0, 2});
        tbl.push_back('{2'b11, 3'b000, DEPTH-1, 32'hA5, 32'h0, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b001, DEPTH-2, 32'h0, 32'h0, 1'b1, 2});
        tbl.push_back('{2'b01, 3'b000, DEPTH-2, 32'hFFFFFFFF, 32'h0, 1'b1, 2});
        tbl.push_back('{2'b00, 3'b010, DEPTH-2, 32'h0, 32'h0000A55A, 1'b0, 2});
        tbl.push_back('{2'b01, 3'b000, 32'h40, 32'h01020304, 32'h0, 1'b0, 2});
        tbl.push_back('{2'b01, 3'b001, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, 2});
        tbl.push_back('{2'b00, 3'b001, 32'h40, 32'h0, 32'h01020304, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b100, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 2});
        tbl.push_back('{2'b00, 3'b011, 32'h3FF, 32'h0, 32'h000000A5, 1'b0, 2});
        for (int i = 0; i < tbl.size(); i++) begin
            model(tbl[i].wm, tbl[i].rm, tbl[i].addr, tbl[i].wd, eo, ef, el);
            run($sformatf("vec%0d", i), tbl[i].wm, tbl[i].rm, tbl[i].addr, tbl[i].wd,
                tbl[i].eo, tbl[i].ef, tbl[i].el, i % 2);
        end

        // Backpressure: response held for 3 cycles while a competing store is offered
        model(2'b00, 3'b001, 32'h10, 32'h0, bp_exp, ef, el);
        @(negedge clk);
        write_mem = 2'b00; read_mem = 3'b001; address = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd2);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            write_mem = 2'b01; read_mem = 3'b000; address = 32'h10; write_data = 32'h0;
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_out", out_mem, bp_exp);
            chk("bp_fault", 32'(fault), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp_consumed", 32'(resp_valid), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_idle_ready", 32'(req_ready), 32'd1);
            chk("bp_no_extra", 32'(resp_valid), 32'd0);
        end
        run_model("bp_reload", 2'b00, 3'b001, 32'h10, 32'h0, 0);

        // Reset during SPLIT of a crossing store
        run_model("sp_init0", 2'b01, 3'b000, 32'h0C, 32'h00000000, 0);
        run_model("sp_init1", 2'b01, 3'b000, 32'h10, 32'hCAFEF00D, 0);
        @(negedge clk);
        write_mem = 2'b01; read_mem = 3'b000; address = 32'h0E; write_data = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("sp_rst_valid", 32'(resp_valid), 32'd0);
        chk("sp_rst_ready", 32'(req_ready), 32'd1);
        chk("sp_rst_out", out_mem, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mem_m[14] = 8'h44;
        mem_m[15] = 8'h33;
        run_model("sp_word0", 2'b00, 3'b001, 32'h0C, 32'h0, 0);
        run_model("sp_word1", 2'b00, 3'b001, 32'h10, 32'h0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  wm;
            logic [2:0]  rm;
            logic [31:0] a;
            int kind, r;
            kind = $urandom_range(0, 9);
            wm = 2'b00;
            rm = 3'b000;
            if (kind == 0) begin
                wm = 2'($urandom_range(0, 3));
                rm = 3'($urandom_range(0, 7));
            end else if (kind < 5) begin
                wm = 2'($urandom_range(1, 3));
            end else begin
                rm = 3'($urandom_range(0, 7));
            end
            r = $urandom_range(0, 19);
            if (r == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else if (r < 3) a = 32'(DEPTH - 4 + $urandom_range(0, 7));
            else a = 32'($urandom_range(0, DEPTH - 1));
            run_model($sformatf("rnd%0d", i), wm, rm, a, $urandom, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
